// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-controlled sequential prefetch into a DEPTH-entry {pc, inst} queue.
// Optional zero-cycle fetch-to-decode path when FETCH_BYPASS_EN is defined.
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                icache_addr,
  output logic                       icache_re,
  input  logic                       icache_ready,
  input  logic [31:0]                icache_dout,
  input  logic                       icache_dout_valid,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  // Stale responses can pile up across several redirects, so give drop_cnt headroom.
  localparam int DW = CW + 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, outstanding;
  logic [DW-1:0]   drop_cnt;
  logic [31:0]     fetch_pc, resp_pc;

  logic [CW:0]     in_flight;
  logic            drop_zero, live_resp, kept, accept, bypass, enq, deq;
  logic            head_valid;
  entry_t          head;
  logic [31:0]     redirect_target;

  assign redirect_target = redirect_pc & ~32'h3;
  assign in_flight       = {1'b0, count} + {1'b0, outstanding};
  assign drop_zero       = (drop_cnt == '0);
  assign live_resp       = icache_dout_valid && drop_zero;
  assign kept            = live_resp && !redirect;

  assign icache_re   = reset_n && !redirect && (in_flight < (CW+1)'(DEPTH));
  assign icache_addr = fetch_pc;
  assign accept      = icache_re && icache_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass = kept && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head_valid = 1'b0;
    head       = '0;
    if (!redirect) begin
      if (count != '0) begin
        head_valid = 1'b1;
        head       = mem[rd_ptr];
      end
`ifdef FETCH_BYPASS_EN
      else if (bypass) begin
        head_valid = 1'b1;
        head       = '{pc: resp_pc, inst: icache_dout};
      end
`endif
    end
  end

  assign inst_valid = head_valid;
  assign inst       = head_valid ? head.inst : `INSTR_NOP;
  assign pc         = head_valid ? head.pc : 32'h0;
  assign occupancy  = count;

  assign deq = head_valid && inst_ready && (count != '0);
  assign enq = kept && !(bypass && inst_ready);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      // Live in-flight requests become stale; the one answered this cycle is dropped now.
      fetch_pc    <= redirect_target;
      resp_pc     <= redirect_target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(icache_dout_valid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (kept)   resp_pc  <= resp_pc + 32'd4;
      if (enq)    wr_ptr   <= wr_ptr + PW'(1);
      if (deq)    rd_ptr   <= rd_ptr + PW'(1);
      if (icache_dout_valid && !drop_zero) drop_cnt <= drop_cnt - DW'(1);
      count       <= count + CW'(enq) - CW'(deq);
      outstanding <= outstanding + CW'(accept) - CW'(live_resp);
    end
  end

  // NOTE: queue storage is not reset; count gates every read so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{pc: resp_pc, inst: icache_dout};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a behavioural in-order instruction cache (response = ~address).
// Build with FETCH_BYPASS_EN defined to exercise the bypass expectations.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic        icache_ready;
  logic [31:0] icache_dout;
  logic        icache_dout_valid;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t q[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_2000)) dut (
    .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_ready(icache_ready),
    .icache_dout(icache_dout), .icache_dout_valid(icache_dout_valid),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .occupancy(occupancy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Cache model: requests sampled mid-cycle, answered in order lat cycles after acceptance.
  initial begin
    icache_dout_valid = 1'b0;
    icache_dout       = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!reset_n) begin
        q.delete();
        icache_dout_valid = 1'b0;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        icache_dout_valid = 1'b1;
        icache_dout       = ~q[0].addr;
        void'(q.pop_front());
      end else begin
        icache_dout_valid = 1'b0;
      end
      @(negedge clk);
      if (!reset_n) q.delete();
      else if (icache_re && icache_ready) q.push_back('{addr: icache_addr, due: cyc + lat});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    inst_ready   = 1'b1;
    icache_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    lat          = 1;
    reset_n      = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    inst_ready   = 1'b1;
    icache_ready = 1'b1;
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%0h want=0", inst_valid); end
    tick();
    total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst got=%h want=00000013", inst); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=00000000", pc); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
    total++; if (icache_re !== 1'b0) begin bad++; $display("FAIL reset_icache_re got=%0h want=0", icache_re); end
    reset_n = 1'b1;
    #1;
    total++; if (icache_re !== 1'b1) begin bad++; $display("FAIL first_req_re got=%0h want=1", icache_re); end
    total++; if (icache_addr !== 32'h0000_2000) begin bad++; $display("FAIL first_req_addr got=%h want=00002000", icache_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req, exp_pc;
    int got, want_got;
    lat = 1;
    do_reset();
    exp_req = 32'h2000;
    exp_pc  = 32'h2000;
    got     = 0;
`ifdef FETCH_BYPASS_EN
    want_got = 11;
`else
    want_got = 10;
`endif
    repeat (12) begin
      @(negedge clk);
      if (icache_re && icache_ready) begin
        total++; if (icache_addr !== exp_req) begin bad++; $display("FAIL stream_req_addr got=%h want=%h", icache_addr, exp_req); end
        exp_req += 32'd4;
      end
      if (inst_valid) begin
        total++; if (pc !== exp_pc) begin bad++; $display("FAIL stream_pc got=%h want=%h", pc, exp_pc); end
        total++; if (inst !== ~exp_pc) begin bad++; $display("FAIL stream_inst got=%h want=%h", inst, ~exp_pc); end
        exp_pc += 32'd4;
        got++;
      end
      total++; if (occupancy > 3'd1) begin bad++; $display("FAIL stream_occupancy got=%0d want<=1", occupancy); end
    end
    total++; if (got != want_got) begin bad++; $display("FAIL stream_count got=%0d want=%0d", got, want_got); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    int accepted;
    lat = 1;
    do_reset();
    inst_ready = 1'b0;
    accepted   = 0;
    repeat (10) begin
      @(negedge clk);
      if (icache_re && icache_ready) accepted++;
    end
    total++; if (accepted != 4) begin bad++; $display("FAIL stall_accepted got=%0d want=4", accepted); end
    total++; if (icache_re !== 1'b0) begin bad++; $display("FAIL stall_icache_re got=%0h want=0", icache_re); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL stall_occupancy got=%0d want=4", occupancy); end
    tick();
    inst_ready = 1'b1;
    exp_pc = 32'h2000;
    repeat (4) begin
      @(negedge clk);
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL drain_valid got=%0h want=1", inst_valid); end
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL drain_pc got=%h want=%h", pc, exp_pc); end
      total++; if (inst !== ~exp_pc) begin bad++; $display("FAIL drain_inst got=%h want=%h", inst, ~exp_pc); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_redirect();
    bit found;
    lat = 3;
    do_reset();
    icache_ready = 1'b0;
    tick();
    icache_ready = 1'b1;
    tick();
    tick();
    icache_ready = 1'b0;
    redirect     = 1'b1;
    redirect_pc  = 32'h0000_3002;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_inst_valid got=%0h want=0", inst_valid); end
    total++; if (icache_re !== 1'b0) begin bad++; $display("FAIL redir_icache_re got=%0h want=0", icache_re); end
    tick();
    redirect     = 1'b0;
    icache_ready = 1'b1;
    @(negedge clk);
    total++; if (icache_re !== 1'b1) begin bad++; $display("FAIL redir_next_re got=%0h want=1", icache_re); end
    total++; if (icache_addr !== 32'h0000_3000) begin bad++; $display("FAIL redir_next_addr got=%h want=00003000", icache_addr); end
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL redir_delivery got=%0h want=1", found); end
    total++; if (pc !== 32'h0000_3000) begin bad++; $display("FAIL redir_first_pc got=%h want=00003000", pc); end
    total++; if (inst !== 32'hFFFF_CFFF) begin bad++; $display("FAIL redir_first_inst got=%h want=ffffcfff", inst); end
  endtask

  task automatic test_redirect_collision();
    bit found;
    lat = 1;
    do_reset();
    repeat (5) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_4000;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL coll_inst_valid got=%0h want=0", inst_valid); end
    total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL coll_inst got=%h want=00000013", inst); end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL coll_occupancy got=%0d want=0", occupancy); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL coll_next_valid got=%0h want=0", inst_valid); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL coll_delivery got=%0h want=1", found); end
    total++; if (pc !== 32'h0000_4000) begin bad++; $display("FAIL coll_first_pc got=%h want=00004000", pc); end
  endtask

  task automatic test_async_reset();
    bit found;
    lat = 1;
    do_reset();
    inst_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (occupancy == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL areset_fill got=%0h want=1", found); end
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL areset_inst_valid got=%0h want=0", inst_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL areset_occupancy got=%0d want=0", occupancy); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL areset_pc got=%h want=00000000", pc); end
    total++; if (icache_re !== 1'b0) begin bad++; $display("FAIL areset_icache_re got=%0h want=0", icache_re); end
    tick();
    tick();
    reset_n    = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    total++; if (icache_addr !== 32'h0000_2000) begin bad++; $display("FAIL areset_restart_addr got=%h want=00002000", icache_addr); end
  endtask

  task automatic test_bypass();
    lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
`ifdef FETCH_BYPASS_EN
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%0h want=1", inst_valid); end
    total++; if (pc !== 32'h0000_2000) begin bad++; $display("FAIL bypass_pc got=%h want=00002000", pc); end
    total++; if (inst !== 32'hFFFF_DFFF) begin bad++; $display("FAIL bypass_inst got=%h want=ffffdfff", inst); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL bypass_occupancy got=%0d want=0", occupancy); end
    @(negedge clk);
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL bypass_occupancy_next got=%0d want=0", occupancy); end
`else
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL nobypass_valid got=%0h want=0", inst_valid); end
    @(negedge clk);
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL nobypass_next_valid got=%0h want=1", inst_valid); end
    total++; if (pc !== 32'h0000_2000) begin bad++; $display("FAIL nobypass_pc got=%h want=00002000", pc); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL nobypass_occupancy got=%0d want=1", occupancy); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collision();
    test_async_reset();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
